lcd_capture: RTL and testbench

Receive-side model of the 4-bit HD44780-style character LCD bus that `display` drives (E, RS, RW, DAT[3:0]). It watches the bus and reassembles nibbles into bytes. It decodes the controller commands and keeps a 2x16 shadow of the screen, in the same 256-bit packing the top level uses for its string data. It is used on the board as a loop-back monitor and in simulation as the scoreboard for `display`.

---
 rtl/lcd_capture.sv | 153 +++++++++++++++
 tb/tb_lcd_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// Receive-side monitor for the 4-bit HD44780-style LCD bus: reassembles nibbles into bytes,
// decodes controller commands and keeps a 2x16 character shadow of the screen.
module lcd_capture #(
    parameter int SYNC = 2
) (
    input  logic         CCLK,
    input  logic         rst_n,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [3:0]   lcd_dat,
    output logic [255:0] screen,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_rs,
    output logic [6:0]   ddram_addr,
    output logic         mode4,
    output logic         disp_on,
    output logic         frame_done,
    output logic         err
);

    typedef enum logic [1:0] {S8, HI, LO} state_t;

    state_t                 state;
    logic [SYNC-1:0][6:0]   sync_q;   // {e, rs, rw, dat[3:0]}, newest at index 0
    logic                   e_prev;
    logic [3:0]             hi_q;
    logic                   hi_rs_q;
    logic                   inc;
    logic                   cgram;

    logic                   e_s, rs_s, rw_s;
    logic [3:0]             dat_s;
    logic                   fall;
    logic                   complete;
    logic [7:0]             cur_byte;
    logic                   cur_rs;
    logic [6:0]             addr_step;
    logic                   wr_hit;
    logic [4:0]             wr_idx;
    logic [7:0]             wr_base;

    assign e_s   = sync_q[SYNC-1][6];
    assign rs_s  = sync_q[SYNC-1][5];
    assign rw_s  = sync_q[SYNC-1][4];
    assign dat_s = sync_q[SYNC-1][3:0];

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        fall      = e_prev && !e_s && !rw_s;
        complete  = fall && ((state == LO) || (state == S8 && !rs_s));
        cur_byte  = (state == S8) ? {dat_s, 4'h0} : {hi_q, dat_s};
        cur_rs    = (state == S8) ? 1'b0 : hi_rs_q;
        addr_step = inc ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
        wr_hit    = 1'b0;
        wr_idx    = {1'b0, ddram_addr[3:0]};
        if (!cgram && ddram_addr[6:4] == 3'b000) begin
            wr_hit = 1'b1;
        end else if (!cgram && ddram_addr[6:4] == 3'b100) begin
            wr_hit = 1'b1;
            wr_idx = {1'b1, ddram_addr[3:0]};
        end
        // Index i lives at [255-8i -: 8], i.e. its low bit is 8*(31-i).
        wr_base   = {~wr_idx, 3'b000};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            e_prev     <= 1'b0;
            state      <= S8;
            hi_q       <= 4'h0;
            hi_rs_q    <= 1'b0;
            inc        <= 1'b1;
            cgram      <= 1'b0;
            // NOTE: the screen shadow is a plain register, so it is reset like any other state.
            screen     <= {32{8'h20}};
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            ddram_addr <= 7'h00;
            mode4      <= 1'b0;
            disp_on    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC-2:0], {lcd_e, lcd_rs, lcd_rw, lcd_dat}};
            e_prev     <= e_s;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;

            if (fall) begin
                case (state)
                    S8:      if (rs_s) err <= 1'b1;
                    HI: begin
                        hi_q    <= dat_s;
                        hi_rs_q <= rs_s;
                        state   <= LO;
                    end
                    default: state <= HI;
                endcase
            end

            // A function-set decoded below overrides the nibble-phase transition above.
            if (complete) begin
                byte_valid <= 1'b1;
                byte_data  <= cur_byte;
                byte_rs    <= cur_rs;
                if (cur_rs) begin
                    ddram_addr <= addr_step;
                    if (wr_hit) begin
                        screen[wr_base +: 8] <= cur_byte;
                        frame_done           <= (wr_idx == 5'd31);
                    end
                end else begin
                    casez (cur_byte)
                        8'b1???????: begin
                            ddram_addr <= cur_byte[6:0];
                            cgram      <= 1'b0;
                        end
                        8'b01??????: cgram <= 1'b1;
                        8'b001?????: begin
                            if (cur_byte[4]) begin
                                state <= S8;
                                mode4 <= 1'b0;
                            end else begin
                                state <= HI;
                                mode4 <= 1'b1;
                            end
                        end
                        8'b0001????: begin
                            if (!cur_byte[3])
                                ddram_addr <= cur_byte[2] ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
                        end
                        8'b00001???: disp_on <= cur_byte[2];
                        8'b000001??: inc <= cur_byte[1];
                        8'b0000001?: ddram_addr <= 7'h00;
                        8'b00000001: begin
                            screen     <= {32{8'h20}};
                            ddram_addr <= 7'h00;
                            inc        <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: drives the 4-bit LCD bus and checks the decoded
// bytes, address counter, mode flags and screen shadow against hand-computed values.
module tb_lcd_capture;

    logic         CCLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         lcd_e = 1'b0;
    logic         lcd_rs = 1'b0;
    logic         lcd_rw = 1'b0;
    logic [3:0]   lcd_dat = 4'h0;
    logic [255:0] screen;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_rs;
    logic [6:0]   ddram_addr;
    logic         mode4;
    logic         disp_on;
    logic         frame_done;
    logic         err;

    localparam logic [255:0] SPACES = {32{8'h20}};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bv_cnt = 0;
    int          fd_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  bq[$];

    lcd_capture #(.SYNC(2)) dut (
        .CCLK       (CCLK),
        .rst_n      (rst_n),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_dat    (lcd_dat),
        .screen     (screen),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .ddram_addr (ddram_addr),
        .mode4      (mode4),
        .disp_on    (disp_on),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 CCLK = ~CCLK;

    always @(negedge CCLK) begin
        if (rst_n) begin
            if (byte_valid) begin
                bv_cnt++;
                bq.push_back(byte_data);
            end
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib);
        @(negedge CCLK);
        lcd_rs  = rs;
        lcd_rw  = rw;
        lcd_dat = nib;
        lcd_e   = 1'b1;
        repeat (4) @(negedge CCLK);
        lcd_e = 1'b0;
        repeat (5) @(negedge CCLK);
    endtask

    task automatic send(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(1'b1, s[i]);
    endtask

    task automatic do_reset();
        @(negedge CCLK);
        rst_n = 1'b0;
        repeat (3) @(negedge CCLK);
        rst_n = 1'b1;
        repeat (2) @(negedge CCLK);
    endtask

    logic [255:0] exp_scr;
    int           bv0;

    initial begin
        do_reset();
        check("rst_screen", screen, SPACES);
        check("rst_mode4", mode4, 0);
        check("rst_addr", ddram_addr, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_byte_data", byte_data, 0);
        repeat (20) @(negedge CCLK);
        check("idle_pulses", bv_cnt + fd_cnt + err_cnt, 0);

        // Init: three 8-bit function sets then switch to 4-bit.
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        strobe(0, 0, 4'h3);
        check("init_s8_mode4", mode4, 0);
        strobe(0, 0, 4'h2);
        check("init_mode4", mode4, 1);
        check("init_s8_bytes", bv_cnt, 4);
        bq.delete();
        send(0, 8'h28);
        send(0, 8'h0C);
        send(0, 8'h06);
        send(0, 8'h01);
        check("init_bv_cnt", bq.size(), 4);
        check("init_b0", bq[0], 8'h28);
        check("init_b1", bq[1], 8'h0C);
        check("init_b2", bq[2], 8'h06);
        check("init_b3", bq[3], 8'h01);
        check("init_disp_on", disp_on, 1);
        check("init_screen", screen, SPACES);
        check("init_addr", ddram_addr, 0);

        // Full frame across both lines.
        fd_cnt = 0;
        send(0, 8'h80);
        send_str("01234567 00 0123");
        check("line1_fd", fd_cnt, 0);
        send(0, 8'hC0);
        send_str("f01d01e01m01w01 ");
        check("frame_screen", screen, {"01234567 00 0123", "f01d01e01m01w01 "});
        check("frame_done_cnt", fd_cnt, 1);
        check("frame_addr", ddram_addr, 7'h50);
        check("frame_byte_rs", byte_rs, 1);
        send(0, 8'h01);
        check("clear_screen", screen, SPACES);
        check("clear_addr", ddram_addr, 0);

        // Decrement with wrap below zero, then increment with wrap above 0x7F.
        send(0, 8'h04);
        send(0, 8'h80);
        send(1, "A");
        exp_scr = SPACES;
        exp_scr[255:248] = "A";
        check("dec_screen", screen, exp_scr);
        check("dec_wrap_addr", ddram_addr, 7'h7F);
        send(0, 8'h06);
        send(0, 8'hFF);
        send(1, "B");
        check("inc_screen", screen, exp_scr);
        check("inc_wrap_addr", ddram_addr, 7'h00);

        // RW=1 strobe between the two nibbles is ignored.
        send(0, 8'h80);
        strobe(1, 0, 4'h4);
        strobe(1, 1, 4'h7);
        strobe(1, 0, 4'h3);
        exp_scr[255:248] = "C";
        check("rw_byte", byte_data, 8'h43);
        check("rw_screen", screen, exp_scr);
        check("rw_addr", ddram_addr, 7'h01);

        // CGRAM write: discarded, address still steps.
        send(0, 8'h40);
        send(1, "Z");
        check("cgram_screen", screen, exp_scr);
        check("cgram_addr", ddram_addr, 7'h02);
        send(0, 8'h80);

        // DL=1 function set reverts to 8-bit mode; data there flags err.
        send(0, 8'h30);
        check("revert_mode4", mode4, 0);
        bv0 = bv_cnt;
        err_cnt = 0;
        strobe(1, 0, 4'h4);
        check("s8_err_cnt", err_cnt, 1);
        check("s8_err_no_bv", bv_cnt - bv0, 0);
        check("s8_err_screen", screen, exp_scr);

        // Reset after a HI nibble drops the half byte.
        strobe(0, 0, 4'h2);
        check("reinit_mode4", mode4, 1);
        strobe(0, 0, 4'h8);
        do_reset();
        check("midrst_mode4", mode4, 0);
        check("midrst_screen", screen, SPACES);
        check("midrst_addr", ddram_addr, 0);
        strobe(0, 0, 4'h2);
        check("midrst_byte", byte_data, 8'h20);
        check("midrst_addr2", ddram_addr, 0);
        check("midrst_mode4_2", mode4, 1);
        send(0, 8'h85);
        check("setaddr", ddram_addr, 7'h05);
        send(0, 8'h14);
        check("cur_right", ddram_addr, 7'h06);
        send(0, 8'h10);
        check("cur_left", ddram_addr, 7'h05);
        send(0, 8'h18);
        check("disp_shift", ddram_addr, 7'h05);
        send(0, 8'h08);
        check("disp_off", disp_on, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
